dmem_ctrl: RTL

Parametrised data-memory controller for the MIPS32 pipeline's MEM stage, replacing the fixed 256-word, word-only, zero-latency array. Adds byte/halfword/word stores with lane enables, sign/zero-extended sub-word loads, and a valid/ready request handshake. A programmable wait-state counter models slower memory and stalls the pipeline through `req_ready`. Misaligned, out-of-range and reserved-size accesses are reported on a response error flag.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_load_align.sv | 29 ++
 rtl/dmem_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Byte-lane enables for an already-aligned access.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b0001 << addr;
            SZ_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Lane extraction and sign/zero extension of a raw memory word for loads.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = word >> {addr, 3'b000};
        b       = shifted[7:0];
        h       = addr[1] ? word[31:16] : word[15:0];
        data    = '0;
        case (size)
            SZ_BYTE: data = {{24{~uns & b[7]}}, b};
            SZ_HALF: data = {{16{~uns & h[15]}}, h};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory: sized stores/loads, wait states, error reporting.
// Optional DMEM_MISALIGN_TRAP_EN turns misalignment into an error.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] mem [DEPTH];

    logic          accept, in_err, oor, rsv;
    logic [1:0]    in_off;
    logic [AW-1:0] in_idx;
    logic [3:0]    wmask;
    logic [31:0]   wdata_rep;

    logic          l_we, l_err, l_uns;
    logic [1:0]    l_size, l_off;
    logic [AW-1:0] l_idx;

    logic          cur_we, cur_err, cur_uns;
    logic [1:0]    cur_size, cur_off;
    logic [AW-1:0] cur_idx;
    logic [31:0]   rd_word, ld_data;
    logic          enter_resp;

    assign req_ready  = (state != ST_WAIT);
    assign resp_valid = (state == ST_RESP);
    assign accept     = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis;
    always_comb begin
        rsv    = (req_size == SZ_RSVD);
        oor    = |(req_addr >> (AW + 2));
        mis    = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        in_err = rsv || oor || mis;
        in_off = req_addr[1:0];
    end
`else
    always_comb begin
        rsv    = (req_size == SZ_RSVD);
        oor    = |(req_addr >> (AW + 2));
        in_err = rsv || oor;
        in_off = req_addr[1:0];
        if (req_size == SZ_WORD)
            in_off = 2'b00;
        else if (req_size == SZ_HALF)
            in_off = {req_addr[1], 1'b0};
    end
`endif

    assign in_idx = req_addr[AW+1:2];
    assign wmask  = lane_mask(req_size, in_off);

    always_comb begin
        wdata_rep = req_wdata;
        case (req_size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    // Stores commit on the accepting edge; the array is never reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !in_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i])
                    mem[in_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // A zero-wait accept enters RESP directly, so it reads the live request.
    assign cur_we   = accept ? req_we       : l_we;
    assign cur_err  = accept ? in_err       : l_err;
    assign cur_uns  = accept ? req_unsigned : l_uns;
    assign cur_size = accept ? req_size     : l_size;
    assign cur_off  = accept ? in_off       : l_off;
    assign cur_idx  = accept ? in_idx       : l_idx;
    assign rd_word  = mem[cur_idx];

    dmem_load_align u_align (
        .word (rd_word),
        .addr (cur_off),
        .size (cur_size),
        .uns  (cur_uns),
        .data (ld_data)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            ST_WAIT: begin
                if (cnt == 4'd0)
                    state_nx = ST_RESP;
                else
                    cnt_nx = cnt - 4'd1;
            end
            default: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = ST_RESP;
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    assign enter_resp = (state_nx == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            l_we       <= 1'b0;
            l_err      <= 1'b0;
            l_uns      <= 1'b0;
            l_size     <= SZ_BYTE;
            l_off      <= '0;
            l_idx      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                l_we   <= req_we;
                l_err  <= in_err;
                l_uns  <= req_unsigned;
                l_size <= req_size;
                l_off  <= in_off;
                l_idx  <= in_idx;
            end
            resp_err   <= enter_resp && cur_err;
            resp_rdata <= (enter_resp && !cur_we && !cur_err) ? ld_data : '0;
        end
    end

endmodule
